reservation_station_ooo: RTL

Parametrised successor reservation station for the fcpu out-of-order core. It sits between dispatch and one functional unit, holding 2**DEPTH_W entries of up to N_OPERANDS source operands each. It snoops N_CDB common data buses and issues the oldest entry whose operands are all ready; an optional IN_ORDER mode restricts issue to the strictly oldest entry. It adds age ordering, multi-CDB wakeup, same-cycle allocation bypass, flush and a held issue handshake.

---
 rtl/fcpu_pkg.sv | 31 +++
 rtl/rsv_age_matrix.sv | 66 ++++++
 rtl/reservation_station_ooo.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fcpu_pkg.sv
// Shared fcpu widths and the storage types used by the reservation station.
//   RSV_ID_W / INSTR_W / DATA_W : tag, opcode and operand widths
//   CDB_W                       : one common data bus word, {tag, data}
//   rsv_entry_t                 : one station slot, sized for the largest operand count
package fcpu_pkg;

  localparam int unsigned RSV_ID_W     = 4;
  localparam int unsigned INSTR_W      = 8;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned CDB_W        = RSV_ID_W + DATA_W;
  localparam int unsigned MAX_OPERANDS = 3;

  typedef struct packed {
    logic [RSV_ID_W-1:0] tag;
    logic [DATA_W-1:0]   data;
  } cdb_t;

  typedef struct packed {
    logic [RSV_ID_W-1:0] tag;
    logic [DATA_W-1:0]   data;
  } rsv_operand_t;

  typedef struct packed {
    logic                                valid;
    logic [RSV_ID_W-1:0]                 dest;
    logic [INSTR_W-1:0]                  instr;
    logic [MAX_OPERANDS-1:0]             filled;
    rsv_operand_t [MAX_OPERANDS-1:0]     op;
  } rsv_entry_t;

endpackage

// File: rtl/rsv_age_matrix.sv
// Age matrix for the reservation station: tracks relative age of every entry and
// picks the oldest requesting one.
//   clk, nrst        : clock, asynchronous active-low reset
//   alloc_valid/idx  : entry being allocated this cycle (becomes youngest)
//   valid            : currently occupied entries (before this cycle's allocation)
//   req              : candidate entries for selection (subset of valid)
//   flush            : clear all age state
//   oldest_oh/idx    : oldest requesting entry, one-hot and encoded (zero when none)
module rsv_age_matrix
  import fcpu_pkg::*;
#(
  parameter int unsigned DEPTH_W = 3,
  localparam int unsigned Depth  = 1 << DEPTH_W
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               alloc_valid,
  input  logic [DEPTH_W-1:0] alloc_idx,
  input  logic [Depth-1:0]   valid,
  input  logic [Depth-1:0]   req,
  input  logic               flush,
  output logic [Depth-1:0]   oldest_oh,
  output logic [DEPTH_W-1:0] oldest_idx
);

  // age_q[i][j] = 1 when entry i is older than entry j.
  logic [Depth-1:0][Depth-1:0] age_q, age_d;
  logic                        blocked;

  always_comb begin
    age_d = age_q;
    if (flush) begin
      age_d = '0;
    end else if (alloc_valid) begin
      // Row and column of the new entry are both rewritten, so stale bits left
      // by its previous occupant never survive.
      for (int i = 0; i < int'(Depth); i++) begin
        age_d[alloc_idx][i] = 1'b0;
        age_d[i][alloc_idx] = valid[i];
      end
    end
  end

  always_comb begin
    oldest_oh  = '0;
    oldest_idx = '0;
    blocked    = 1'b0;
    for (int i = 0; i < int'(Depth); i++) begin
      blocked = 1'b0;
      for (int j = 0; j < int'(Depth); j++) begin
        if (req[j] && age_q[j][i]) blocked = 1'b1;
      end
      oldest_oh[i] = req[i] && !blocked;
      if (oldest_oh[i]) oldest_idx = oldest_idx | DEPTH_W'(i);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/reservation_station_ooo.sv
// Reservation station between dispatch and one functional unit.
//   clk, nrst          : clock, asynchronous active-low reset
//   i_flush            : drop every entry at the next edge
//   i_valid/i_data/i_filled/i_ready : dispatch {dest, instr, op[N-1..0] {tag, data}}
//   o_valid/o_data/o_ready          : issue {dest, instr, data[N-1..0]}, held until accepted
//   cdb_valid/cdb      : N_CDB result buses, each {tag, data}
//   o_count            : occupied entries
module reservation_station_ooo
  import fcpu_pkg::*;
#(
  parameter int unsigned N_OPERANDS = 2,
  parameter int unsigned DEPTH_W    = 3,
  parameter int unsigned N_CDB      = 1,
  parameter int unsigned IN_ORDER   = 0,
  localparam int unsigned Depth     = 1 << DEPTH_W,
  localparam int unsigned OpW       = RSV_ID_W + DATA_W,
  localparam int unsigned InW       = RSV_ID_W + INSTR_W + N_OPERANDS * OpW,
  localparam int unsigned OutW      = RSV_ID_W + INSTR_W + N_OPERANDS * DATA_W
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   i_flush,
  input  logic                   i_valid,
  input  logic [InW-1:0]         i_data,
  input  logic [N_OPERANDS-1:0]  i_filled,
  output logic                   i_ready,
  output logic                   o_valid,
  output logic [OutW-1:0]        o_data,
  input  logic                   o_ready,
  input  logic [N_CDB-1:0]       cdb_valid,
  input  logic [N_CDB*CDB_W-1:0] cdb,
  output logic [DEPTH_W:0]       o_count
);

  rsv_entry_t         entry_q [Depth];
  rsv_entry_t         entry_d [Depth];
  rsv_entry_t         new_entry, sel_entry;
  logic [DEPTH_W:0]   count_q, count_d;
  logic               lock_q, lock_d;
  logic [DEPTH_W-1:0] lock_idx_q, lock_idx_d;
  logic [Depth-1:0]   valid_mask, ready_mask, req_mask, oldest_oh;
  logic [DEPTH_W-1:0] oldest_idx, alloc_idx, sel_idx;
  logic               alloc, fire, cand;
  logic [DATA_W:0]    wake_res, byp_res;
  logic               unused_slots;

  // Returns {hit, data}; the lowest-index matching bus wins.
  function automatic logic [DATA_W:0] snoop(input logic [RSV_ID_W-1:0]    tag,
                                            input logic [N_CDB-1:0]       vld,
                                            input logic [N_CDB*CDB_W-1:0] bus);
    cdb_t c;
    snoop = '0;
    for (int b = int'(N_CDB) - 1; b >= 0; b--) begin
      c = bus[b*CDB_W +: CDB_W];
      if (vld[b] && c.tag == tag) snoop = {1'b1, c.data};
    end
  endfunction

  always_comb begin
    for (int i = 0; i < int'(Depth); i++) begin
      valid_mask[i] = entry_q[i].valid;
      ready_mask[i] = entry_q[i].valid && (&entry_q[i].filled[N_OPERANDS-1:0]);
    end
    req_mask = (IN_ORDER != 0) ? valid_mask : ready_mask;
  end

  // Lowest-index free entry.
  always_comb begin
    alloc_idx = '0;
    for (int i = int'(Depth) - 1; i >= 0; i--) begin
      if (!entry_q[i].valid) alloc_idx = DEPTH_W'(i);
    end
  end

  assign i_ready = !i_flush && (count_q != (DEPTH_W+1)'(Depth));
  assign alloc   = i_valid && i_ready;

  rsv_age_matrix #(
    .DEPTH_W(DEPTH_W)
  ) u_age (
    .clk        (clk),
    .nrst       (nrst),
    .alloc_valid(alloc),
    .alloc_idx  (alloc_idx),
    .valid      (valid_mask),
    .req        (req_mask),
    .flush      (i_flush),
    .oldest_oh  (oldest_oh),
    .oldest_idx (oldest_idx)
  );

  // A locked entry is already fully filled, so it stays issuable until accepted.
  assign sel_idx   = lock_q ? lock_idx_q : oldest_idx;
  assign cand      = lock_q || ((|oldest_oh) && ready_mask[oldest_idx]);
  assign o_valid   = cand && !i_flush;
  assign fire      = o_valid && o_ready;
  assign sel_entry = entry_q[sel_idx];
  assign o_count   = count_q;

  always_comb begin
    o_data = '0;
    if (o_valid) begin
      o_data[OutW-1 -: RSV_ID_W]              = sel_entry.dest;
      o_data[N_OPERANDS*DATA_W +: INSTR_W]    = sel_entry.instr;
      for (int k = 0; k < int'(N_OPERANDS); k++) begin
        o_data[k*DATA_W +: DATA_W] = sel_entry.op[k].data;
      end
    end
  end

  // Incoming entry, with operands captured from a same-cycle broadcast.
  always_comb begin
    new_entry       = '0;
    byp_res         = '0;
    new_entry.valid = 1'b1;
    new_entry.dest  = i_data[InW-1 -: RSV_ID_W];
    new_entry.instr = i_data[N_OPERANDS*OpW +: INSTR_W];
    for (int k = 0; k < int'(N_OPERANDS); k++) begin
      new_entry.op[k]     = rsv_operand_t'(i_data[k*OpW +: OpW]);
      new_entry.filled[k] = i_filled[k];
      if (!i_filled[k]) begin
        byp_res = snoop(new_entry.op[k].tag, cdb_valid, cdb);
        if (byp_res[DATA_W]) begin
          new_entry.filled[k]  = 1'b1;
          new_entry.op[k].data = byp_res[DATA_W-1:0];
        end
      end
    end
  end

  always_comb begin
    wake_res = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      entry_d[i] = entry_q[i];
      if (entry_q[i].valid) begin
        for (int k = 0; k < int'(N_OPERANDS); k++) begin
          if (!entry_q[i].filled[k]) begin
            wake_res = snoop(entry_q[i].op[k].tag, cdb_valid, cdb);
            if (wake_res[DATA_W]) begin
              entry_d[i].filled[k]  = 1'b1;
              entry_d[i].op[k].data = wake_res[DATA_W-1:0];
            end
          end
        end
      end
    end
    if (fire)  entry_d[sel_idx].valid = 1'b0;
    if (alloc) entry_d[alloc_idx] = new_entry;
    if (i_flush) begin
      for (int i = 0; i < int'(Depth); i++) entry_d[i].valid = 1'b0;
    end
  end

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    count_d    = count_q + (DEPTH_W+1)'(alloc) - (DEPTH_W+1)'(fire);
    if (i_flush) begin
      lock_d  = 1'b0;
      count_d = '0;
    end else if (fire) begin
      lock_d = 1'b0;
    end else if (o_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = sel_idx;
    end
  end

  // Operand slots above N_OPERANDS stay zero and are never read.
  always_comb begin
    unused_slots = 1'b0;
    for (int i = 0; i < int'(Depth); i++) begin
      for (int k = int'(N_OPERANDS); k < int'(MAX_OPERANDS); k++) begin
        unused_slots = unused_slots ^ entry_q[i].filled[k] ^ (^entry_q[i].op[k]);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(Depth); i++) entry_q[i] <= '0;
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int i = 0; i < int'(Depth); i++) entry_q[i] <= entry_d[i];
      count_q    <= count_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule
